// File: rtl/alu_pkg.sv
// Shared definitions for the alu_pipe block.
//   - Opcode encodings (OP_ADD .. OP_NEG)
//   - Bit positions inside the 4-bit {N,Z,C,V} flags vector
//   - Control FSM state encoding
//   - mk_flags(): packs individual flag bits into the flags vector
// Related build macro: ALU_PIPE_MUL_EN (see alu_pipe.sv).
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_ADC  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_SBB  = 3;
    localparam int unsigned OP_MUL  = 4;
    localparam int unsigned OP_AND  = 8;
    localparam int unsigned OP_OR   = 9;
    localparam int unsigned OP_XOR  = 10;
    localparam int unsigned OP_NAND = 11;
    localparam int unsigned OP_NOR  = 12;
    localparam int unsigned OP_XNOR = 13;
    localparam int unsigned OP_NOT  = 14;
    localparam int unsigned OP_NEG  = 15;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } alu_state_e;

    function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                            input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier used by alu_pipe for MUL.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       latch a/b, clear accumulator and counter, begin iterating
//   a, b        multiplicand / multiplier (WIDTH bits)
//   done        high during the last of the WIDTH iterations
//   product     low WIDTH bits of the accumulated product
//   overflow    any bit of the high product half is set
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    count_q;
    logic               running_q;

    // Combinational so the controller can leave its MUL state on the same edge
    // that performs the final accumulate.
    assign done = running_q && (count_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= {{WIDTH{1'b0}}, a};
            acc_q     <= '0;
            mplier_q  <= b;
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CntW'(1);
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

    assign product  = acc_q[WIDTH-1:0];
    assign overflow = |acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Registered-output integer ALU with valid/ready handshakes and a carry
// register for ADC/SBB chaining.
// Build macro: ALU_PIPE_MUL_EN -- when defined, opcode 4 (MUL) runs on the
// iterative multiplier (latency WIDTH+1); when undefined, MUL is illegal.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operation handshake
//   opcode, a, b         operation select and operands
//   out_valid, out_ready result handshake
//   out                  result
//   flags                {N,Z,C,V} of the held result
//   illegal              held result came from an unsupported opcode
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             illegal
);

    alu_state_e       state_q, state_d;
    logic             carry_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             load;
    logic             is_arith;
    logic             is_mul;
    logic             legal;
    logic             cin;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] single_res;
    logic             single_c, single_v;

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Opcode decode and adder operand selection.
    always_comb begin
        op_a      = a;
        op_b      = b;
        cin       = 1'b0;
        is_arith  = 1'b0;
        is_mul    = 1'b0;
        legal     = 1'b1;
        logic_res = '0;
        case (opcode)
            OPW'(OP_ADD): is_arith = 1'b1;
            OPW'(OP_ADC): begin
                is_arith = 1'b1;
                cin      = carry_q;
            end
            OPW'(OP_SUB): begin
                is_arith = 1'b1;
                op_b     = ~b;
                cin      = 1'b1;
            end
            OPW'(OP_SBB): begin
                is_arith = 1'b1;
                op_b     = ~b;
                cin      = carry_q;
            end
            OPW'(OP_NEG): begin
                is_arith = 1'b1;
                op_a     = ~a;
                op_b     = '0;
                cin      = 1'b1;
            end
            OPW'(OP_AND):  logic_res = a & b;
            OPW'(OP_OR):   logic_res = a | b;
            OPW'(OP_XOR):  logic_res = a ^ b;
            OPW'(OP_NAND): logic_res = ~(a & b);
            OPW'(OP_NOR):  logic_res = ~(a | b);
            OPW'(OP_XNOR): logic_res = ~(a ^ b);
            OPW'(OP_NOT):  logic_res = ~a;
`ifdef ALU_PIPE_MUL_EN
            OPW'(OP_MUL):  is_mul = 1'b1;
`endif
            default:       legal = 1'b0;
        endcase
    end

    assign sum        = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    // Illegal opcodes leave logic_res at zero, giving out=0 with only Z set.
    assign single_res = is_arith ? sum[WIDTH-1:0] : logic_res;
    assign single_c   = is_arith & sum[WIDTH];
    assign single_v   = is_arith & (op_a[WIDTH-1] == op_b[WIDTH-1])
                                 & (sum[WIDTH-1] != op_a[WIDTH-1]);

`ifdef ALU_PIPE_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_ovf;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_mul),
        .a        (a),
        .b        (b),
        .done     (mul_done),
        .product  (mul_product),
        .overflow (mul_ovf)
    );
`endif

    always_comb begin
        state_d = state_q;
`ifdef ALU_PIPE_MUL_EN
        unique case (state_q)
            StIdle:  if (accept && is_mul) state_d = StMul;
            StMul:   if (mul_done) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
`endif
    end

    // Result register load: single-cycle ops at acceptance, MUL from DONE.
    always_comb begin
        load      = 1'b0;
        out_d     = out_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        if (accept && !is_mul) begin
            load      = 1'b1;
            out_d     = single_res;
            flags_d   = mk_flags(single_res[WIDTH-1], single_res == '0, single_c, single_v);
            illegal_d = !legal;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (state_q == StDone) begin
            load      = 1'b1;
            out_d     = mul_product;
            flags_d   = mk_flags(mul_product[WIDTH-1], mul_product == '0, 1'b0, mul_ovf);
            illegal_d = 1'b0;
        end
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            if (accept && is_arith) begin
                carry_q <= sum[WIDTH];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    alu_pipe #(
        .WIDTH (W),
        .OPW   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;  // {N,Z,C,V}
        logic        ill;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one operation at the current negedge; returns at the next negedge.
    task automatic op1(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string name, input logic [31:0] res, input logic [3:0] flg,
                           input logic ill);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_out"}, out, res);
        chk({name, "_flags"}, flags, flg);
        chk({name, "_illegal"}, illegal, ill);
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic mul_run(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] res, input logic [3:0] flg);
        int lat;
        logic busy_bad;
        busy_bad = 1'b0;
        op1(5'd4, x, y);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, W + 1);
        chk({name, "_busy_in_ready"}, busy_bad, 1'b0);
        chk_res(name, res, flg, 1'b0);
    endtask
`endif

    initial begin
        vecs[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0};
        vecs[1]  = '{5'd1,  32'h00000005, 32'h00000006, 32'h0000000C, 4'b0000, 1'b0};
        vecs[2]  = '{5'd2,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1'b0};
        vecs[3]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0};
        vecs[4]  = '{5'd3,  32'h0000000A, 32'h00000003, 32'h00000006, 4'b0010, 1'b0};
        vecs[5]  = '{5'd3,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1'b0};
        vecs[6]  = '{5'd6,  32'h12345678, 32'h00000001, 32'h00000000, 4'b0100, 1'b1};
        vecs[7]  = '{5'd1,  32'h00000000, 32'h00000000, 32'h00000001, 4'b0000, 1'b0};
        vecs[8]  = '{5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0};
        vecs[9]  = '{5'd9,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1'b0};
        vecs[10] = '{5'd10, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[11] = '{5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1'b0};
        vecs[12] = '{5'd12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[13] = '{5'd13, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[14] = '{5'd14, 32'h00000000, 32'h00000123, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[15] = '{5'd15, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[16] = '{5'd15, 32'h80000000, 32'h00000000, 32'h80000000, 4'b1001, 1'b0};
        vecs[17] = '{5'd15, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0110, 1'b0};
        vecs[18] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1'b1};
        vecs[19] = '{5'd1,  32'h00000000, 32'h00000000, 32'h00000001, 4'b0000, 1'b0};
        vecs[20] = '{5'd7,  32'h00000001, 32'h00000001, 32'h00000000, 4'b0100, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out", out, 32'h0);
        chk("reset_flags", flags, 4'h0);
        chk("reset_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back stream, one op per cycle, carry chained through the table.
        for (int i = 0; i < 21; i++) begin
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            op1(vecs[i].opc, vecs[i].a, vecs[i].b);
            chk_res($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg, vecs[i].ill);
        end

        // Asynchronous reset mid-stream clears outputs and the carry register.
        opcode   = 5'd0;
        a        = 32'h1;
        b        = 32'h1;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_out", out, 32'h0);
        chk("midreset_flags", flags, 4'h0);
        chk("midreset_illegal", illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op1(5'd1, 32'h0, 32'h0);
        chk_res("post_reset_adc", 32'h0, 4'b0100, 1'b0);
        @(negedge clk);
        chk("drain_out_valid", out_valid, 1'b0);

        // Backpressure: result held, no new accept.
        out_ready = 1'b0;
        op1(5'd10, 32'h0000FFFF, 32'h00FF00FF);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out", i), out, 32'h00FFFF00);
            chk($sformatf("bp%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
            @(negedge clk);
        end
        // Release together with a new op: replaced without a bubble.
        out_ready = 1'b1;
        opcode    = 5'd12;
        a         = 32'h0;
        b         = 32'h0;
        in_valid  = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_res("release_nor", 32'hFFFFFFFF, 4'b1000, 1'b0);
        @(negedge clk);
        chk("release_drained", out_valid, 1'b0);

        // Opcode 4 with carry set beforehand; carry must survive it.
        op1(5'd0, 32'hFFFFFFFF, 32'h1);
        chk_res("pre_mul_add", 32'h0, 4'b0110, 1'b0);
`ifdef ALU_PIPE_MUL_EN
        mul_run("mul_big", 32'h00010000, 32'h00010000, 32'h0, 4'b0101);
        mul_run("mul_small", 32'h7, 32'h6, 32'd42, 4'b0000);
        op1(5'd0, 32'hFFFFFFFF, 32'h1);
`else
        op1(5'd4, 32'h7, 32'h6);
        chk_res("mul_disabled", 32'h0, 4'b0100, 1'b1);
`endif
        op1(5'd1, 32'h0, 32'h0);
        chk_res("post_mul_adc", 32'h1, 4'b0000, 1'b0);

`ifdef ALU_PIPE_MUL_EN
        // Reset during a multiply abandons it with no output.
        begin
            logic seen;
            @(negedge clk);
            op1(5'd4, 32'h3, 32'h3);
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            seen  = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("mul_reset_no_output", seen, 1'b0);
            chk("mul_reset_in_ready", in_ready, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
